// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter and its
// digit-correction cell.
package bin2bcd_seq_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StConv = 1'b1
  } state_e;

  localparam int unsigned BcdDigitW = 4;
  localparam logic [BcdDigitW-1:0] Add3Thresh = 4'd5;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction cell: digits of 5 or more get +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3
  import bin2bcd_seq_pkg::*;
(
  input  logic [BcdDigitW-1:0] digit_i,
  output logic [BcdDigitW-1:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= Add3Thresh) begin
      digit_o = digit_i + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: samples bin_i on start_i, then runs one
// double-dabble iteration per clock and pulses done_o with the packed result.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned DWIDTH = 7,
  parameter int unsigned DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic [DWIDTH-1:0]             bin_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [BcdDigitW*DIGITS-1:0]   bcd_o
);

  localparam int unsigned AccW = BcdDigitW * DIGITS;
  localparam int unsigned CntW = $clog2(DWIDTH + 1);

  state_e              r_state;
  logic [DWIDTH-1:0]   r_shift;
  logic [AccW-1:0]     r_acc;
  logic [CntW-1:0]     r_cnt;
  logic                r_busy;
  logic                r_done;
  logic [AccW-1:0]     r_bcd;

  logic [AccW-1:0]     w_acc_corr;
  logic [AccW-1:0]     w_acc_next;
  logic [DWIDTH-1:0]   w_shift_next;
  logic                w_last;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .digit_i (r_acc[g*BcdDigitW +: BcdDigitW]),
      .digit_o (w_acc_corr[g*BcdDigitW +: BcdDigitW])
    );
  end

  // Correct first, then shift {acc, shift} left with the shift MSB entering acc bit 0.
  assign w_acc_next   = {w_acc_corr[AccW-2:0], r_shift[DWIDTH-1]};
  assign w_shift_next = {r_shift[DWIDTH-2:0], 1'b0};
  assign w_last       = (r_cnt == CntW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_shift <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bcd   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (start_i) begin
            r_shift <= bin_i;
            r_acc   <= '0;
            r_cnt   <= CntW'(DWIDTH);
            r_busy  <= 1'b1;
            r_state <= StConv;
          end
        end
        StConv: begin
          r_acc   <= w_acc_next;
          r_shift <= w_shift_next;
          r_cnt   <= r_cnt - CntW'(1);
          if (w_last) begin
            r_bcd   <= w_acc_next;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy_o = r_busy;
  assign done_o = r_done;
  assign bcd_o  = r_bcd;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: cycle-level reference model with a
// per-cycle compare, literal spot checks, random traffic and full sweeps.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  bin = '0;
  logic        busy_o, done_o;
  logic [11:0] bcd_o;

  logic        start10 = 1'b0;
  logic [9:0]  bin10 = '0;
  logic        busy10, done10;
  logic [15:0] bcd10;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.DWIDTH(7), .DIGITS(3)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .bin_i   (bin),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .bcd_o   (bcd_o)
  );

  bin2bcd_seq #(.DWIDTH(10), .DIGITS(4)) u_dut10 (
    .clk     (clk),
    .rst     (rst),
    .start_i (start10),
    .bin_i   (bin10),
    .busy_o  (busy10),
    .done_o  (done10),
    .bcd_o   (bcd10)
  );

  // Decimal digits of v, units in [3:0].
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    r = '0;
    t = v;
    for (int d = 0; d < 4; d++) begin
      r[d*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: cycles left in the current conversion (0 = idle).
  bit          m_valid = 1'b0;
  int          m_left = 0;
  int          m_val = 0;
  logic        m_done = 1'b0;
  logic [15:0] m_bcd = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_left  = 0;
      m_done  = 1'b0;
      m_bcd   = '0;
    end else if (m_valid) begin
      if (m_left == 0) begin
        m_done = 1'b0;
        if (start) begin
          m_val  = int'(bin);
          m_left = 7;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_bcd  = to_bcd(m_val);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", 16'(busy_o), 16'(m_left != 0));
      chk("done", 16'(done_o), 16'(m_done));
      chk("bcd", 16'(bcd_o), m_bcd);
    end
  end

  task automatic pulse_start(input int v);
    @(negedge clk); #1;
    start = 1'b1;
    bin   = 7'(v);
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    while (!done_o && n < 40) begin
      if (busy_o) nbusy++;
      @(negedge clk); #1;
      n++;
    end
    if (!done_o) chk("done_timeout", 16'(done_o), 16'd1);
  endtask

  task automatic conv_check(input int v, input logic [15:0] lit, input string nm);
    int n, nb;
    pulse_start(v);
    wait_done(n, nb);
    chk({nm, "_bcd"}, 16'(bcd_o), lit);
    chk({nm, "_lat"}, 16'(n), 16'd7);
    chk({nm, "_busycyc"}, 16'(nb), 16'd7);
  endtask

  task automatic conv10(input int v);
    int n;
    @(negedge clk); #1;
    start10 = 1'b1;
    bin10   = 10'(v);
    @(negedge clk); #1;
    start10 = 1'b0;
    n = 0;
    while (!done10 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    chk("w10_bcd", bcd10, to_bcd(v));
    chk("w10_lat", 16'(n), 16'd10);
  endtask

  initial begin
    int n, nb, last, cyc, ndone;
    logic [6:0] cnt;

    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_busy", 16'(busy_o), 16'd0);
    chk("rst_done", 16'(done_o), 16'd0);
    chk("rst_bcd", 16'(bcd_o), 16'h000);

    conv_check(0, 16'h000, "zero");
    conv_check(100, 16'h100, "v100");
    conv_check(127, 16'h127, "v127");
    conv_check(99, 16'h099, "v99");

    // start held high: back-to-back conversions, bin_i glitch mid-flight
    @(negedge clk); #1;
    start = 1'b1;
    bin = 7'd42;
    last = -1; cyc = 0; ndone = 0;
    while (ndone < 3 && cyc < 60) begin
      @(negedge clk); #1;
      cyc++;
      if (cyc == 3) bin = 7'd5;
      if (cyc == 5) bin = 7'd42;
      if (done_o) begin
        chk("held_bcd", 16'(bcd_o), 16'h042);
        if (last >= 0) chk("held_period", 16'(cyc - last), 16'd8);
        last = cyc;
        ndone++;
      end
    end
    chk("held_count", 16'(ndone), 16'd3);
    start = 1'b0;
    repeat (10) @(negedge clk);

    // reset mid-conversion
    pulse_start(88);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk); #1 rst = 1'b0;
    chk("midrst_busy", 16'(busy_o), 16'd0);
    chk("midrst_bcd", 16'(bcd_o), 16'h000);
    ndone = 0;
    repeat (12) begin
      @(negedge clk); #1;
      if (done_o) ndone++;
    end
    chk("midrst_nodone", 16'(ndone), 16'd0);
    conv_check(88, 16'h088, "after_rst");

    // upstream counter feeding the converter, across the 127 -> 0 wrap
    cnt = 7'd124;
    for (int i = 0; i < 8; i++) begin
      conv_check(int'(cnt), to_bcd(int'(cnt)), "cnt");
      cnt = cnt + 7'd1;
    end

    // random traffic, with stray start pulses during conversion
    for (int i = 0; i < 150; i++) begin
      pulse_start(int'($urandom_range(0, 127)));
      if ($urandom_range(0, 1) == 1) begin
        start = 1'b1;
        bin = 7'($urandom_range(0, 127));
        @(negedge clk); #1;
        start = 1'b0;
      end
      wait_done(n, nb);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    for (int v = 0; v < 128; v++) conv_check(v, to_bcd(v), "sweep7");
    for (int v = 0; v < 1024; v++) conv10(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter placed directly downstream of the 7-bit event counter. It samples the counter's binary value on request and converts it to packed BCD digits for the display and readout logic. The conversion uses a shift-and-add-3 (double-dabble) algorithm, one bit per clock, with a start/busy/done handshake. This keeps the datapath to one digit-correction cell per digit instead of a wide combinational divider.

## Interface
- `DWIDTH`, default 7: width of the binary input; matches the counter width.
- `DIGITS`, default 3: number of BCD output digits; must satisfy 10^DIGITS ≥ 2^DWIDTH.
- `clk`  input  1: sole clock, rising-edge.
- `rst`  input  1: reset, synchronous, active-high.
- `start_i`  input  1: conversion request; sampled only in IDLE.
- `bin_i`  input  DWIDTH: unsigned binary value, typically the counter's `cnt_o`.
- `busy_o`  output  1: high while a conversion is in progress.
- `done_o`  output  1: single-cycle pulse; `bcd_o` updated in this cycle.
- `bcd_o`  output  4*DIGITS: packed BCD result; digit 0 (units) in bits [3:0].

## Operation
- FSM states: IDLE, CONV.
- IDLE with `start_i`=1:
  - latch `bin_i` into the shift register;
  - clear the BCD accumulator;
  - load the iteration counter with DWIDTH;
  - go to CONV.
- IDLE with `start_i`=0: hold state; all outputs hold.
- CONV, each cycle:
  - every accumulator digit ≥ 5 gets +3 (mod 16, 4-bit);
  - then {accumulator, shift reg} shifts left by 1, with the shift-reg MSB entering accumulator bit 0;
  - the iteration counter decrements.
- CONV, last iteration (counter = 1):
  - the corrected and shifted accumulator is written to `bcd_o`;
  - `done_o` is set for one cycle;
  - return to IDLE.
- `start_i` during CONV is ignored, not queued.
- `bin_i` changes after the sampling edge have no effect on the conversion in flight.
- Iteration counter width: $clog2(DWIDTH+1). The accumulator is 4*DIGITS bits and never overflows when the DIGITS rule holds.
- `bcd_o` holds the last result until the next `done_o`.
- Reset (any state, including mid-CONV):
  - state ← IDLE;
  - `busy_o`=0, `done_o`=0, `bcd_o`=0;
  - accumulator, shift register and iteration counter cleared;
  - the partial conversion is discarded and `done_o` is never emitted for it.

## Timing
- All outputs are registered.
- Reset values: `busy_o`=0, `done_o`=0, `bcd_o`=0.
- `start_i` sampled at edge k:
  - `busy_o`=1 after edges k … k+DWIDTH-1;
  - `done_o`=1 and the new `bcd_o` appear after edge k+DWIDTH;
  - `busy_o`=0 in the `done_o` cycle.
- Latency from start sample to `done_o` is DWIDTH cycles (7 at the default).
- Back-to-back: `start_i` asserted during the `done_o` cycle is accepted, since state is IDLE. Maximum throughput is one conversion per DWIDTH+1 cycles.
- `done_o` never stays high for two consecutive cycles.

## Structure
- Shared package/header holds:
  - the FSM state encoding (IDLE=0, CONV=1);
  - the BCD digit width constant (4);
  - the add-3 threshold constant (5).
- Sub-module `bcd_add3`: combinational 4-bit digit correction cell (in ≥ 5 → in+3, else in).
  - Instantiated DIGITS times via generate.
  - Also reused by later display logic.
- Top level holds the FSM, iteration counter, shift/accumulator register and output registers.

## Test plan
- Reset, then `start_i`, `bin_i`=0 → `done_o` 7 cycles later, `bcd_o`=12'h000, `busy_o` high exactly 7 cycles.
- `bin_i`=100 → `bcd_o`=12'h100. Then `bin_i`=127 → 12'h127. Then `bin_i`=99 → 12'h099. Each has single-cycle `done_o` and 7-cycle latency.
- `start_i` held high continuously with `bin_i`=42:
  - conversions accepted only in IDLE;
  - `done_o` every 8 cycles;
  - `bcd_o`=12'h042;
  - `bin_i` changed to 5 mid-conversion does not affect the current result.
- `rst` asserted after 3 CONV cycles of `bin_i`=88 → next cycle IDLE, `busy_o`=0, `bcd_o`=0, no `done_o`. A subsequent start with 88 → 12'h088.
- Integration: upstream counter enabled, start pulsed on each count → every result equals the decimal digits of the sampled count, including wrap 127→0 (12'h127 then 12'h000).
- Exhaustive sweep 0…127 against a reference model → all match. Also `DWIDTH`=10, `DIGITS`=4 sweep 0…1023 → all match.
